// File: rtl/hazard_control_unit_pkg.sv
// rtl/hazard_control_unit_pkg.sv - shared encodings for the pipeline hazard control unit
package hazard_control_unit_pkg;

    localparam logic [1:0] FWD_RF      = 2'b00;
    localparam logic [1:0] FWD_W       = 2'b01;
    localparam logic [1:0] FWD_M       = 2'b10;
    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_t;

    // M is the younger producer, so it wins over W; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic       wr_m,
        input logic [4:0] rd_m,
        input logic       wr_w,
        input logic [4:0] rd_w,
        input logic [4:0] rs
    );
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return FWD_M;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return FWD_W;
        end else begin
            return FWD_RF;
        end
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// rtl/hazard_control_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_control_unit_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [4:0]       rs1E;
    logic [4:0]       rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic             MemReqM;
    logic             mem_ready;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushW;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW,
        output RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, mem_ready,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        input  ForwardAE, ForwardBE, mem_fault, stall_cycles, flush_events
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, RdE, RdM, RdW,
        input  RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, mem_ready,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
        output ForwardAE, ForwardBE, mem_fault, stall_cycles, flush_events
    );

endinterface

// File: rtl/hazard_control_unit_forward_unit.sv
// rtl/hazard_control_unit_forward_unit.sv - E-stage operand forwarding selects
module hazard_control_unit_forward_unit
    import hazard_control_unit_pkg::*;
(
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE
);

    always_comb begin
        ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, rs1E);
        ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, rs2E);
    end

endmodule

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - stall/flush/forward sequencer for the 5-stage core
module hazard_control_unit
    import hazard_control_unit_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_control_unit_if.slave bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT) + 1;

    mem_state_t        state;
    mem_state_t        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              fault_set;
    logic              fault;
    logic              timeout_hit;
    logic              mem_stall;
    logic              lw_stall;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_w;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    hazard_control_unit_forward_unit u_forward (
        .rs1E      (bus.rs1E),
        .rs2E      (bus.rs2E),
        .RdM       (bus.RdM),
        .RdW       (bus.RdW),
        .RegWriteM (bus.RegWriteM),
        .RegWriteW (bus.RegWriteW),
        .ForwardAE (fwd_a),
        .ForwardBE (fwd_b)
    );

    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign mem_stall   = bus.MemReqM && !bus.mem_ready && !timeout_hit;
    assign lw_stall    = (bus.ResultSrcE == RESULT_LOAD) && (bus.RdE != 5'd0) &&
                         ((bus.RdE == bus.rs1D) || (bus.RdE == bus.rs2D));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            fault    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (fault_set) begin
                fault <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        fault_set    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.MemReqM && !bus.mem_ready) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_WAIT: begin
                if (!bus.MemReqM || bus.mem_ready) begin
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                end else if (timeout_hit) begin
                    // Give up on the access: release the pipe and flag it.
                    state_nxt    = ST_IDLE;
                    wait_cnt_nxt = '0;
                    fault_set    = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_W'(1);
                end
            end
            default: begin
                state_nxt    = ST_IDLE;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    // A memory freeze holds any pending redirect or load-use stall in place.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
                flush_w = 1'b1;
            end else if (bus.PCSrcE) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (lw_stall) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_f) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (bus.PCSrcE && flush_d) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.StallF       = stall_f;
    assign bus.StallD       = stall_d;
    assign bus.StallE       = stall_e;
    assign bus.StallM       = stall_m;
    assign bus.FlushD       = flush_d;
    assign bus.FlushE       = flush_e;
    assign bus.FlushW       = flush_w;
    assign bus.ForwardAE    = fwd_a;
    assign bus.ForwardBE    = fwd_b;
    assign bus.mem_fault    = fault;
    assign bus.stall_cycles = stall_cnt;
    assign bus.flush_events = flush_cnt;

endmodule
